// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter in front of one single-ported memory
// One transaction outstanding at a time; data port has priority, bounded by a fetch starvation counter.
module mem_port_arbiter #(
    parameter int BUS_WIDTH    = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [BUS_WIDTH-1:0] i_addr,
    output logic                 i_gnt,
    output logic                 i_rvalid,
    output logic [BUS_WIDTH-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [BUS_WIDTH-1:0] d_addr,
    input  logic [BUS_WIDTH-1:0] d_wdata,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [BUS_WIDTH-1:0] d_rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [BUS_WIDTH-1:0] mem_addr,
    output logic [BUS_WIDTH-1:0] mem_wdata,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [BUS_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [1:0] O_NONE  = 2'd0;
    localparam logic [1:0] O_FETCH = 2'd1;
    localparam logic [1:0] O_DATA  = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [1:0]           r_owner;
    logic [CNT_WIDTH-1:0] r_starve_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_next;

    logic                 r_mem_req;
    logic                 r_mem_we;
    logic [BUS_WIDTH-1:0] r_mem_addr;
    logic [BUS_WIDTH-1:0] r_mem_wdata;
    logic                 r_i_gnt;
    logic                 r_i_rvalid;
    logic [BUS_WIDTH-1:0] r_i_rdata;
    logic                 r_d_gnt;
    logic                 r_d_rvalid;
    logic [BUS_WIDTH-1:0] r_d_rdata;

    logic w_any_req;
    logic w_cnt_full;
    logic w_pick_fetch;
    logic w_launch;
    logic w_accept;
    logic w_resp;

    assign w_any_req    = i_req | d_req;
    assign w_cnt_full   = (r_starve_cnt == CNT_WIDTH'(STARVE_LIMIT));
    assign w_pick_fetch = i_req & (~d_req | w_cnt_full);

    // Counter only grows while fetch is actually waiting behind a data win.
    always_comb begin
        w_cnt_next = '0;
        if (!w_pick_fetch && i_req) begin
            w_cnt_next = w_cnt_full ? r_starve_cnt : r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next_state = S_ISSUE;
            S_ISSUE: if (r_mem_req && mem_gnt) w_next_state = S_WAIT;
            S_WAIT:  if (mem_rvalid) w_next_state = w_any_req ? S_ISSUE : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // mem_rvalid outside WAIT is stale and must not reach either requester.
    always_comb begin
        w_launch = 1'b0;
        w_accept = 1'b0;
        w_resp   = 1'b0;
        case (r_state)
            S_IDLE:  w_launch = w_any_req;
            S_ISSUE: w_accept = r_mem_req & mem_gnt;
            S_WAIT: begin
                w_resp   = mem_rvalid;
                w_launch = mem_rvalid & w_any_req;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_owner      <= O_NONE;
            r_starve_cnt <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_i_gnt      <= 1'b0;
            r_i_rvalid   <= 1'b0;
            r_i_rdata    <= '0;
            r_d_gnt      <= 1'b0;
            r_d_rvalid   <= 1'b0;
            r_d_rdata    <= '0;
        end else begin
            r_i_gnt    <= 1'b0;
            r_d_gnt    <= 1'b0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;

            if (w_accept) begin
                r_mem_req <= 1'b0;
                r_i_gnt   <= (r_owner == O_FETCH);
                r_d_gnt   <= (r_owner == O_DATA);
            end

            if (w_resp) begin
                r_owner <= O_NONE;
                if (r_owner == O_FETCH) begin
                    r_i_rvalid <= 1'b1;
                    r_i_rdata  <= mem_rdata;
                end
                if (r_owner == O_DATA) begin
                    r_d_rvalid <= 1'b1;
                    r_d_rdata  <= mem_rdata;
                end
            end

            // Placed after the response so a same-edge re-arbitration sets the new owner.
            if (w_launch) begin
                r_mem_req    <= 1'b1;
                r_starve_cnt <= w_cnt_next;
                if (w_pick_fetch) begin
                    r_owner     <= O_FETCH;
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= i_addr;
                    r_mem_wdata <= '0;
                end else begin
                    r_owner     <= O_DATA;
                    r_mem_we    <= d_we;
                    r_mem_addr  <= d_addr;
                    r_mem_wdata <= d_wdata;
                end
            end
        end
    end

    assign i_gnt     = r_i_gnt;
    assign i_rvalid  = r_i_rvalid;
    assign i_rdata   = r_i_rdata;
    assign d_gnt     = r_d_gnt;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
